// File: rtl/ifm_bram_sched.sv
// IFM BRAM tile read sequencer with a 2-entry output FIFO, sharing the BRAM port with loader writes.
// First word 3 cycles after start; reads stall when FIFO+in-flight would exceed 2; writes get idle slots.
module ifm_bram_sched #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 128
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]    wr_data,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] base_addr,
  input  logic [7:0]               num_rows,
  input  logic [7:0]               row_len,
  input  logic [ADDRESS_WIDTH-1:0] row_stride,
  output logic                     busy,
  output logic                     done,
  output logic [DATA_WIDTH-1:0]    rd_data,
  output logic                     rd_data_valid,
  input  logic                     rd_ready,
  output logic [ADDRESS_WIDTH-1:0] ifm_address,
  output logic [DATA_WIDTH-1:0]    data_in,
  output logic                     write_en,
  output logic                     ifm_address_valid,
  input  logic [DATA_WIDTH-1:0]    ifm_out
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                   state, state_nxt;
  logic [7:0]               rows_q, len_q, r_cnt, c_cnt;
  logic [ADDRESS_WIDTH-1:0] stride_q, row_addr, col_addr;
  logic                     inflight;
  logic [1:0]               occ;
  logic [DATA_WIDTH-1:0]    buf0, buf1;
  logic [2:0]               pending;
  logic                     pop, issue, row_end, last_issue, grant;

  assign pop           = (occ != 2'd0) && rd_ready;
  assign rd_data_valid = (occ != 2'd0);
  assign rd_data       = buf0;

  // Slots already committed after this cycle's pop; a pop needs occ>=1 so no underflow.
  assign pending    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (state == ISSUE) && (pending < 3'd2);
  assign row_end    = (c_cnt == len_q - 8'd1);
  assign last_issue = issue && row_end && (r_cnt == rows_q - 8'd1);

  assign wr_ready = !reset && !issue;
  assign grant    = wr_valid && wr_ready;

  assign busy = (state == ISSUE) || (state == DRAIN);
  assign done = (state == DONE);

  always_comb begin
    ifm_address       = '0;
    data_in           = '0;
    write_en          = 1'b0;
    ifm_address_valid = 1'b0;
    if (issue) begin
      ifm_address       = col_addr;
      ifm_address_valid = 1'b1;
    end else if (grant) begin
      ifm_address       = wr_addr;
      data_in           = wr_data;
      write_en          = 1'b1;
      ifm_address_valid = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = (num_rows == 8'd0 || row_len == 8'd0) ? DONE : ISSUE;
      ISSUE: if (last_issue) state_nxt = DRAIN;
      // Leave once the FIFO empties this cycle and nothing is still coming from the BRAM.
      DRAIN: if (!inflight && (occ == 2'd0 || (occ == 2'd1 && pop))) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      rows_q   <= '0;
      len_q    <= '0;
      stride_q <= '0;
      r_cnt    <= '0;
      c_cnt    <= '0;
      row_addr <= '0;
      col_addr <= '0;
      inflight <= 1'b0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (state == IDLE && start) begin
        rows_q   <= num_rows;
        len_q    <= row_len;
        stride_q <= row_stride;
        row_addr <= base_addr;
        col_addr <= base_addr;
        r_cnt    <= '0;
        c_cnt    <= '0;
      end else if (issue) begin
        if (row_end) begin
          c_cnt    <= '0;
          r_cnt    <= r_cnt + 8'd1;
          row_addr <= row_addr + stride_q;
          col_addr <= row_addr + stride_q;
        end else begin
          c_cnt    <= c_cnt + 8'd1;
          col_addr <= col_addr + ADDRESS_WIDTH'(16);
        end
      end
    end
  end

  // Output FIFO: buf0 is the head; the BRAM word arrives the cycle after its issue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      occ  <= '0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      case ({inflight, pop})
        2'b10: begin
          if (occ == 2'd0) buf0 <= ifm_out;
          else             buf1 <= ifm_out;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          buf0 <= buf1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            buf0 <= ifm_out;
          end else begin
            buf0 <= buf1;
            buf1 <= ifm_out;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
